// File: rtl/flag_alu_unit.sv
// flag_alu_unit: execute-stage ALU with NZCV flag generation.
// Holds the architectural flags and one saved copy used across exception entry and return.
// Flag packing is {V,C,Z,N} in bits [3:0].
module flag_alu_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [3:0]        opcode,
   input  logic              s_bit,
   input  logic              cond_pass,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              shift_carry,
   input  logic              msr_we,
   input  logic [3:0]        msr_flags,
   input  logic              exc_save,
   input  logic              exc_restore,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic              out_wb,
   output logic [3:0]        flags,
   output logic [3:0]        flags_fwd,
   output logic [3:0]        spsr_flags
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_RSB = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_RSC = 4'b0111;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_TEQ = 4'b1001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_CMN = 4'b1011;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_BIC = 4'b1110;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam int MSB = DATA_W - 1;

   logic [3:0]        flags_q, flags_d;
   logic [3:0]        spsr_q, spsr_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              wb_q, wb_d;

   logic [DATA_W-1:0] alu_x, alu_y;
   logic              alu_cin;
   logic              alu_arith;
   logic [DATA_W-1:0] alu_logic;
   logic [DATA_W:0]   alu_sum;
   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_flags;
   logic              alu_wb;
   logic              exec;

   assign exec = in_valid & cond_pass;

   // Datapath: select adder operands or logical result, then derive NZCV.
   always_comb begin
      alu_x     = op_a;
      alu_y     = op_b;
      alu_cin   = 1'b0;
      alu_arith = 1'b1;
      alu_logic = '0;
      unique case (opcode)
         OP_SUB, OP_CMP: begin
            alu_y   = ~op_b;
            alu_cin = 1'b1;
         end
         OP_RSB: begin
            alu_x   = op_b;
            alu_y   = ~op_a;
            alu_cin = 1'b1;
         end
         OP_ADD, OP_CMN: begin
            alu_cin = 1'b0;
         end
         OP_ADC: begin
            alu_cin = flags_q[2];
         end
         OP_SBC: begin
            alu_y   = ~op_b;
            alu_cin = flags_q[2];
         end
         OP_RSC: begin
            alu_x   = op_b;
            alu_y   = ~op_a;
            alu_cin = flags_q[2];
         end
         OP_AND, OP_TST: begin
            alu_arith = 1'b0;
            alu_logic = op_a & op_b;
         end
         OP_EOR, OP_TEQ: begin
            alu_arith = 1'b0;
            alu_logic = op_a ^ op_b;
         end
         OP_ORR: begin
            alu_arith = 1'b0;
            alu_logic = op_a | op_b;
         end
         OP_MOV: begin
            alu_arith = 1'b0;
            alu_logic = op_b;
         end
         OP_BIC: begin
            alu_arith = 1'b0;
            alu_logic = op_a & ~op_b;
         end
         OP_MVN: begin
            alu_arith = 1'b0;
            alu_logic = ~op_b;
         end
         default: begin
            alu_arith = 1'b1;
         end
      endcase

      alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {{DATA_W{1'b0}}, alu_cin};
      alu_res = alu_arith ? alu_sum[DATA_W-1:0] : alu_logic;

      alu_flags[0] = alu_res[MSB];
      alu_flags[1] = (alu_res == '0);
      if (alu_arith) begin
         alu_flags[2] = alu_sum[DATA_W];
         alu_flags[3] = (alu_x[MSB] == alu_y[MSB]) & (alu_sum[MSB] != alu_x[MSB]);
      end else begin
         // Logical ops take C from the shifter and leave V alone.
         alu_flags[2] = shift_carry;
         alu_flags[3] = flags_q[3];
      end

      // Compare/test opcodes only update flags, never Rd.
      alu_wb = (opcode[3:2] != 2'b10);
   end

   // Next-state selection; flags follow reset > restore > MSR > S-bit > hold.
   always_comb begin
      flags_d  = flags_q;
      spsr_d   = spsr_q;
      valid_d  = exec;
      result_d = result_q;
      wb_d     = wb_q;

      if (exec) begin
         result_d = alu_res;
         wb_d     = alu_wb;
      end

      if (exc_restore) begin
         flags_d = spsr_q;
      end else if (msr_we) begin
         flags_d = msr_flags;
      end else if (exec && s_bit) begin
         flags_d = alu_flags;
      end

      // Save uses the pre-update flags, so save+restore together swaps them.
      if (exc_save) begin
         spsr_d = flags_q;
      end

      if (rst) begin
         flags_d  = '0;
         spsr_d   = '0;
         valid_d  = 1'b0;
         result_d = '0;
         wb_d     = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q  <= '0;
         spsr_q   <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         wb_q     <= 1'b0;
      end else begin
         flags_q  <= flags_d;
         spsr_q   <= spsr_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         wb_q     <= wb_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_wb     = wb_q;
   assign flags      = flags_q;
   assign flags_fwd  = flags_d;
   assign spsr_flags = spsr_q;

endmodule

// File: tb/tb_flag_alu_unit.sv
// Testbench for flag_alu_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_flag_alu_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  opcode;
   logic        s_bit;
   logic        cond_pass;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        shift_carry;
   logic        msr_we;
   logic [3:0]  msr_flags;
   logic        exc_save;
   logic        exc_restore;
   logic        out_valid;
   logic [31:0] out_result;
   logic        out_wb;
   logic [3:0]  flags;
   logic [3:0]  flags_fwd;
   logic [3:0]  spsr_flags;

   int errors = 0;
   int checks = 0;

   flag_alu_unit #(.DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .opcode      (opcode),
      .s_bit       (s_bit),
      .cond_pass   (cond_pass),
      .op_a        (op_a),
      .op_b        (op_b),
      .shift_carry (shift_carry),
      .msr_we      (msr_we),
      .msr_flags   (msr_flags),
      .exc_save    (exc_save),
      .exc_restore (exc_restore),
      .out_valid   (out_valid),
      .out_result  (out_result),
      .out_wb      (out_wb),
      .flags       (flags),
      .flags_fwd   (flags_fwd),
      .spsr_flags  (spsr_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: ARM data-processing semantics in plain integer arithmetic.
   function automatic void model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] fl, input logic sc,
                                     output logic [31:0] res, output logic wb, output logic [3:0] nf);
      logic [31:0]     xv, yv, lr;
      int              cin;
      bit              arith;
      longint unsigned usum;
      longint          ssum;
      bit              n, z, c, v;
      arith = 1'b1;
      xv = a; yv = b; cin = 0; lr = '0;
      case (op)
         4'h2, 4'hA: begin yv = ~b; cin = 1; end
         4'h3:       begin xv = b; yv = ~a; cin = 1; end
         4'h4, 4'hB: begin cin = 0; end
         4'h5:       begin cin = int'(fl[2]); end
         4'h6:       begin yv = ~b; cin = int'(fl[2]); end
         4'h7:       begin xv = b; yv = ~a; cin = int'(fl[2]); end
         4'h0, 4'h8: begin arith = 1'b0; lr = a & b; end
         4'h1, 4'h9: begin arith = 1'b0; lr = a ^ b; end
         4'hC:       begin arith = 1'b0; lr = a | b; end
         4'hD:       begin arith = 1'b0; lr = b; end
         4'hE:       begin arith = 1'b0; lr = a & ~b; end
         default:    begin arith = 1'b0; lr = ~b; end
      endcase
      if (arith) begin
         usum = longint'(xv) + longint'(yv) + longint'(cin);
         ssum = longint'($signed(xv)) + longint'($signed(yv)) + longint'(cin);
         res  = usum[31:0];
         c    = usum[32];
         v    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      end else begin
         res = lr;
         c   = sc;
         v   = fl[3];
      end
      n  = res[31];
      z  = (res == 32'd0);
      nf = {v, c, z, n};
      wb = !(op >= 4'h8 && op <= 4'hB);
   endfunction

   logic [3:0]  m_flags, m_spsr;
   logic        m_valid, m_wb;
   logic [31:0] m_res;
   bit          m_known = 1'b0;

   // Every cycle: compare registered outputs and the forwarded flags with the model, then advance it.
   always @(negedge clk) begin : cmp
      logic [31:0] r;
      logic        w;
      logic [3:0]  nf, n_flags, n_spsr;
      bit          ex;
      if (m_known) begin
         chk("model_out_valid", 32'(out_valid), 32'(m_valid));
         chk("model_out_result", out_result, m_res);
         chk("model_out_wb", 32'(out_wb), 32'(m_wb));
         chk("model_flags", 32'(flags), 32'(m_flags));
         chk("model_spsr_flags", 32'(spsr_flags), 32'(m_spsr));
      end
      if (rst) begin
         m_flags = 4'h0; m_spsr = 4'h0; m_valid = 1'b0; m_res = '0; m_wb = 1'b0;
         m_known = 1'b1;
      end else if (m_known) begin
         model_alu(opcode, op_a, op_b, m_flags, shift_carry, r, w, nf);
         ex = in_valid && cond_pass;
         n_spsr = exc_save ? m_flags : m_spsr;
         if (exc_restore)       n_flags = m_spsr;
         else if (msr_we)       n_flags = msr_flags;
         else if (ex && s_bit)  n_flags = nf;
         else                   n_flags = m_flags;
         chk("model_flags_fwd", 32'(flags_fwd), 32'(n_flags));
         m_flags = n_flags;
         m_spsr  = n_spsr;
         m_valid = ex;
         if (ex) begin
            m_res = r;
            m_wb  = w;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rst = 1'b0; in_valid = 1'b0; opcode = 4'h0; s_bit = 1'b0; cond_pass = 1'b0;
      op_a = '0; op_b = '0; shift_carry = 1'b0; msr_we = 1'b0; msr_flags = 4'h0;
      exc_save = 1'b0; exc_restore = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic cp, input logic sc);
      in_valid = 1'b1; opcode = op; op_a = a; op_b = b; s_bit = s; cond_pass = cp; shift_carry = sc;
   endtask

   task automatic set_flags(input logic [3:0] f);
      quiet();
      msr_we = 1'b1; msr_flags = f;
      tick();
      quiet();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: pick = 32'h0000_0000;
         1: pick = 32'h0000_0001;
         2: pick = 32'h7FFF_FFFF;
         3: pick = 32'h8000_0000;
         4: pick = 32'hFFFF_FFFF;
         default: pick = $urandom;
      endcase
   endfunction

   initial begin
      quiet();
      rst = 1'b1;
      tick();
      tick();
      chk("reset_flags", 32'(flags), 32'h0);
      chk("reset_spsr", 32'(spsr_flags), 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_out_result", out_result, 32'h0);
      chk("reset_out_wb", 32'(out_wb), 32'h0);
      quiet();
      #1;
      chk("idle_flags_fwd", 32'(flags_fwd), 32'h0);

      // ADDS overflow into the sign bit.
      issue(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0);
      tick();
      chk("adds_result", out_result, 32'h8000_0000);
      chk("adds_wb", 32'(out_wb), 32'h1);
      chk("adds_flags", 32'(flags), 32'b1001);

      // CMP equal: no writeback, forwarded flags visible in the issue cycle.
      issue(4'hA, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
      #1;
      chk("cmp_flags_fwd", 32'(flags_fwd), 32'b0110);
      tick();
      chk("cmp_wb", 32'(out_wb), 32'h0);
      chk("cmp_flags", 32'(flags), 32'b0110);

      // Carry-in chains through registered C.
      set_flags(4'b0100);
      issue(4'h5, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("adcs_result", out_result, 32'h0);
      chk("adcs_flags", 32'(flags), 32'b0110);
      issue(4'h6, 32'd3, 32'd1, 1'b1, 1'b1, 1'b0);
      tick();
      chk("sbcs_result", out_result, 32'd2);
      chk("sbcs_flags", 32'(flags), 32'b0100);

      // Logical op keeps V, takes C from shifter; squashed copy changes nothing.
      set_flags(4'b1000);
      issue(4'hD, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
      tick();
      chk("movs_flags", 32'(flags), 32'b1110);
      issue(4'hD, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0);
      tick();
      chk("squash_valid", 32'(out_valid), 32'h0);
      chk("squash_flags", 32'(flags), 32'b1110);

      // Exception save alongside a flag setter, then restore beating MSR and S.
      set_flags(4'b0100);
      issue(4'h4, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
      exc_save = 1'b1;
      tick();
      chk("save_spsr", 32'(spsr_flags), 32'b0100);
      chk("save_flags", 32'(flags), 32'b0000);
      quiet();
      issue(4'h0, 32'h0000_00F0, 32'h0000_00FF, 1'b1, 1'b1, 1'b0);
      msr_we = 1'b1; msr_flags = 4'b1111; exc_restore = 1'b1;
      tick();
      chk("restore_flags", 32'(flags), 32'b0100);
      chk("restore_valid", 32'(out_valid), 32'h1);
      chk("restore_result", out_result, 32'h0000_00F0);

      // Reset in the middle of a stream, with other sources also asserted.
      quiet();
      issue(4'h4, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0);
      tick();
      rst = 1'b1; exc_save = 1'b1; msr_we = 1'b1; msr_flags = 4'hF;
      tick();
      chk("midrst_valid", 32'(out_valid), 32'h0);
      chk("midrst_flags", 32'(flags), 32'h0);
      chk("midrst_spsr", 32'(spsr_flags), 32'h0);
      quiet();
      issue(4'h4, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
      tick();
      chk("resume_valid", 32'(out_valid), 32'h1);
      chk("resume_result", out_result, 32'd2);

      // Randomized traffic; the compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         quiet();
         rst         = ($urandom_range(0, 79) == 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         opcode      = 4'($urandom_range(0, 15));
         s_bit       = 1'($urandom_range(0, 1));
         cond_pass   = ($urandom_range(0, 4) != 0);
         op_a        = pick();
         op_b        = pick();
         shift_carry = 1'($urandom_range(0, 1));
         msr_we      = ($urandom_range(0, 7) == 0);
         msr_flags   = 4'($urandom_range(0, 15));
         exc_save    = ($urandom_range(0, 9) == 0);
         exc_restore = ($urandom_range(0, 9) == 0);
         tick();
      end
      quiet();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
